// File: rtl/xcore_bpu_pkg.sv
// Shared definitions for the Xcore BPU prediction tables: table FSM states,
// default counter width, init encoding and the saturating counter update.
package xcore_bpu_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } bim_state_e;

  localparam int BIM_CNT_W_DEF = 2;
  localparam int BIM_CNT_W_MAX = 4;

  // Weakly not-taken: the value just below the taken threshold.
  function automatic int unsigned init_val(input int unsigned cnt_w);
    return (32'd1 << (cnt_w - 32'd1)) - 32'd1;
  endfunction

  // Saturating increment on taken, saturating decrement on not-taken.
  // Works on the widest supported counter; callers truncate to their width.
  function automatic logic [BIM_CNT_W_MAX-1:0] sat_next(
    input logic [BIM_CNT_W_MAX-1:0] cnt,
    input logic                     taken,
    input int unsigned              cnt_w
  );
    logic [BIM_CNT_W_MAX-1:0] max_v;
    max_v = BIM_CNT_W_MAX'((32'd1 << cnt_w) - 32'd1);
    if (taken) begin
      sat_next = (cnt >= max_v) ? max_v : cnt + BIM_CNT_W_MAX'(1);
    end else begin
      sat_next = (cnt == '0) ? '0 : cnt - BIM_CNT_W_MAX'(1);
    end
  endfunction

endpackage

// File: rtl/xcore_if_bim_sat_if.sv
// Lookup / commit-update / clear bundle between the fetch BPU and the
// bimodal table. master = requester, slave = the table.
interface xcore_if_bim_sat_if #(
  parameter int IDX_W = 10,
  parameter int CNT_W = 2
);
  logic             i_bim_clr;
  logic             i_bpu_vld;
  logic [IDX_W-1:0] i_bpu_addr;
  logic             i_cmt_req;
  logic [IDX_W-1:0] i_cmt_addr;
  logic             i_cmt_taken;
  logic             o_bim_ready;
  logic             o_bim_vld;
  logic [CNT_W-1:0] o_bim_cnt;
  logic             o_bim_taken;

  modport master (
    output i_bim_clr, i_bpu_vld, i_bpu_addr, i_cmt_req, i_cmt_addr, i_cmt_taken,
    input  o_bim_ready, o_bim_vld, o_bim_cnt, o_bim_taken
  );

  modport slave (
    input  i_bim_clr, i_bpu_vld, i_bpu_addr, i_cmt_req, i_cmt_addr, i_cmt_taken,
    output o_bim_ready, o_bim_vld, o_bim_cnt, o_bim_taken
  );
endinterface

// File: rtl/xcore_bim_ram.sv
// Counter array: one synchronous write port, two combinational read ports.
module xcore_bim_ram #(
  parameter int ENTRIES = 1024,
  parameter int IDX_W   = $clog2(ENTRIES),
  parameter int CNT_W   = 2
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [IDX_W-1:0] waddr_i,
  input  logic [CNT_W-1:0] wdata_i,
  input  logic [IDX_W-1:0] raddr_a_i,
  output logic [CNT_W-1:0] rdata_a_o,
  input  logic [IDX_W-1:0] raddr_b_i,
  output logic [CNT_W-1:0] rdata_b_o
);

  logic [CNT_W-1:0] mem_q [ENTRIES];

  // Single write port, shared by the init sweep and the update pipeline.
  // NOTE: the array has no reset; the init sweep gives it defined contents,
  // and a reset branch here would turn the RAM into a huge flop bank.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_a_o = mem_q[raddr_a_i];
  assign rdata_b_o = mem_q[raddr_b_i];

endmodule

// File: rtl/xcore_if_bim_sat.sv
// Bimodal branch-prediction table: 1-cycle lookup with update bypass,
// 2-stage read-modify-write commit update, hardware init sweep.
module xcore_if_bim_sat
  import xcore_bpu_pkg::*;
#(
  parameter int             ENTRIES  = 1024,
  parameter int             IDX_W    = $clog2(ENTRIES),
  parameter int             CNT_W    = BIM_CNT_W_DEF,
  parameter logic [CNT_W-1:0] INIT_VAL = CNT_W'(init_val(CNT_W))
) (
  input logic               i_sys_clk,
  input logic               i_sys_rst,
  xcore_if_bim_sat_if.slave bim
);

  bim_state_e       state_q, state_d;
  logic [IDX_W-1:0] sweep_idx_q, sweep_idx_d;
  logic             sweep_we;
  logic             clr;

  logic             u1_vld_q, u1_vld_d;
  logic [IDX_W-1:0] u1_addr_q, u1_addr_d;
  logic             u1_taken_q, u1_taken_d;

  logic [CNT_W-1:0] u2_rd_cnt;
  logic [CNT_W-1:0] u2_new_cnt;
  logic             u2_we;

  logic             ram_we;
  logic [IDX_W-1:0] ram_waddr;
  logic [CNT_W-1:0] ram_wdata;
  logic [CNT_W-1:0] lk_rd_cnt;

  logic             vld_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign clr = bim.i_bim_clr;

  // FSM next state and sweep index; clear restarts the sweep from either state.
  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    sweep_idx_d = sweep_idx_q;
    sweep_we    = 1'b0;
    if (clr) begin
      state_d     = ST_INIT;
      sweep_idx_d = '0;
    end else begin
      case (state_q)
        ST_INIT: begin
          sweep_we = 1'b1;
          if (sweep_idx_q == IDX_W'(ENTRIES - 1)) begin
            state_d     = ST_RUN;
            sweep_idx_d = '0;
          end else begin
            sweep_idx_d = sweep_idx_q + IDX_W'(1);
          end
        end
        ST_RUN:  ;
        default: state_d = ST_INIT;
      endcase
    end
  end

  // FSM state and sweep index registers.
  always_ff @(posedge i_sys_clk or negedge i_sys_rst) begin
    if (!i_sys_rst) begin
      state_q     <= ST_INIT;
      sweep_idx_q <= '0;
    end else begin
      state_q     <= state_d;
      sweep_idx_q <= sweep_idx_d;
    end
  end

  // U1 capture: commits are only accepted in RUN outside a clear cycle.
  always_comb begin
    u1_vld_d   = bim.i_cmt_req && (state_q == ST_RUN) && !clr;
    u1_addr_d  = bim.i_cmt_addr;
    u1_taken_d = bim.i_cmt_taken;
  end

  // U1 pipeline registers.
  always_ff @(posedge i_sys_clk or negedge i_sys_rst) begin
    if (!i_sys_rst) begin
      u1_vld_q   <= 1'b0;
      u1_addr_q  <= '0;
      u1_taken_q <= 1'b0;
    end else begin
      u1_vld_q   <= u1_vld_d;
      u1_addr_q  <= u1_addr_d;
      u1_taken_q <= u1_taken_d;
    end
  end

  // U2: read the current counter and compute its saturated successor.
  // The write lands at the end of U2, so a following U2 always reads it.
  always_comb begin
    u2_we      = u1_vld_q && !clr;
    u2_new_cnt = CNT_W'(sat_next(BIM_CNT_W_MAX'(u2_rd_cnt), u1_taken_q, CNT_W));
  end

  // Write-port arbitration: the sweep owns the port while in INIT.
  always_comb begin
    ram_we    = sweep_we || u2_we;
    ram_waddr = u1_addr_q;
    ram_wdata = u2_new_cnt;
    if (sweep_we) begin
      ram_waddr = sweep_idx_q;
      ram_wdata = INIT_VAL;
    end
  end

  xcore_bim_ram #(
    .ENTRIES (ENTRIES),
    .IDX_W   (IDX_W),
    .CNT_W   (CNT_W)
  ) u_ram (
    .clk       (i_sys_clk),
    .we_i      (ram_we),
    .waddr_i   (ram_waddr),
    .wdata_i   (ram_wdata),
    .raddr_a_i (bim.i_bpu_addr),
    .rdata_a_o (lk_rd_cnt),
    .raddr_b_i (u1_addr_q),
    .rdata_b_o (u2_rd_cnt)
  );

  // Lookup mux: INIT value during the sweep or clear, else bypass the
  // in-flight U2 write, else the stored counter. Holds when no request.
  always_comb begin
    cnt_d = cnt_q;
    if (bim.i_bpu_vld) begin
      if ((state_q == ST_INIT) || clr) begin
        cnt_d = INIT_VAL;
      end else if (u2_we && (u1_addr_q == bim.i_bpu_addr)) begin
        cnt_d = u2_new_cnt;
      end else begin
        cnt_d = lk_rd_cnt;
      end
    end
  end

  // Lookup output registers.
  always_ff @(posedge i_sys_clk or negedge i_sys_rst) begin
    if (!i_sys_rst) begin
      vld_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      vld_q <= bim.i_bpu_vld;
      cnt_q <= cnt_d;
    end
  end

  assign bim.o_bim_ready = (state_q == ST_RUN);
  assign bim.o_bim_vld   = vld_q;
  assign bim.o_bim_cnt   = cnt_q;
  assign bim.o_bim_taken = cnt_q[CNT_W-1];

endmodule

// File: tb/tb_xcore_if_bim_sat.sv
// Directed bench for xcore_if_bim_sat with ENTRIES=16, CNT_W=2 (INIT_VAL=1).
module tb_xcore_if_bim_sat;

  localparam int ENTRIES = 16;
  localparam int IDX_W   = 4;
  localparam int CNT_W   = 2;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  xcore_if_bim_sat_if #(.IDX_W(IDX_W), .CNT_W(CNT_W)) bim_if ();

  xcore_if_bim_sat #(
    .ENTRIES (ENTRIES),
    .CNT_W   (CNT_W)
  ) dut (
    .i_sys_clk (clk),
    .i_sys_rst (rst_n),
    .bim       (bim_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic             bpu_vld;
    logic [IDX_W-1:0] bpu_addr;
    logic             cmt_req;
    logic [IDX_W-1:0] cmt_addr;
    logic             cmt_taken;
    logic             clr;
    logic             exp_vld;
    logic             exp_ready;
    logic             chk_cnt;
    logic [CNT_W-1:0] exp_cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic bv, input logic [IDX_W-1:0] ba,
                              input logic cr, input logic [IDX_W-1:0] ca,
                              input logic ct, input logic cl,
                              input logic ev, input logic er, input logic ec,
                              input logic [CNT_W-1:0] cnt);
    vec_t v;
    v.bpu_vld = bv;  v.bpu_addr = ba;
    v.cmt_req = cr;  v.cmt_addr = ca;  v.cmt_taken = ct;
    v.clr = cl;
    v.exp_vld = ev;  v.exp_ready = er; v.chk_cnt = ec;  v.exp_cnt = cnt;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    bim_if.i_bim_clr   = 1'b0;
    bim_if.i_bpu_vld   = 1'b0;
    bim_if.i_bpu_addr  = '0;
    bim_if.i_cmt_req   = 1'b0;
    bim_if.i_cmt_addr  = '0;
    bim_if.i_cmt_taken = 1'b0;
  endtask

  task automatic lookup_check(input string name, input logic [IDX_W-1:0] a,
                              input logic [CNT_W-1:0] exp);
    bim_if.i_bpu_vld  = 1'b1;
    bim_if.i_bpu_addr = a;
    tick();
    check({name, "_vld"}, 32'(bim_if.o_bim_vld), 32'd1);
    check({name, "_cnt"}, 32'(bim_if.o_bim_cnt), 32'(exp));
    check({name, "_tkn"}, 32'(bim_if.o_bim_taken), 32'(exp[CNT_W-1]));
    bim_if.i_bpu_vld  = 1'b0;
  endtask

  task automatic sweep_check(input string name);
    for (int i = 0; i < ENTRIES; i++) begin
      check($sformatf("%s_rdy0_c%0d", name, i + 1), 32'(bim_if.o_bim_ready), 32'd0);
      tick();
    end
    check($sformatf("%s_rdy1_c%0d", name, ENTRIES + 1), 32'(bim_if.o_bim_ready), 32'd1);
  endtask

  initial begin
    vec_t v;
    n_checks = 0;
    n_errors = 0;
    drive_idle();
    rst_n = 1'b1;

    // ---------------- reset and initial sweep ----------------
    #2 rst_n = 1'b0;
    #1;
    check("rst_ready", 32'(bim_if.o_bim_ready), 32'd0);
    check("rst_vld",   32'(bim_if.o_bim_vld),   32'd0);
    check("rst_cnt",   32'(bim_if.o_bim_cnt),   32'd0);
    check("rst_taken", 32'(bim_if.o_bim_taken), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    sweep_check("init");

    // ---------------- vector table ----------------
    // A: every index holds INIT_VAL=1 after the sweep.
    for (int i = 0; i < ENTRIES; i++)
      vecs.push_back(mk(1'b1, IDX_W'(i), 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2'd1));
    vecs.push_back(mk(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0));
    // B: index 5 taken x3 (1->2->3->3), lookup at +2, then a 4th taken.
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk(1'b0, 4'd0, 1'b1, 4'd5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0));
    vecs.push_back(mk(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0));
    vecs.push_back(mk(1'b1, 4'd5, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2'd3));
    vecs.push_back(mk(1'b0, 4'd0, 1'b1, 4'd5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0));
    vecs.push_back(mk(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0));
    vecs.push_back(mk(1'b1, 4'd5, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2'd3));
    // C: index 9 not-taken x3 (1->0->0->0), then one taken gives 1.
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk(1'b0, 4'd0, 1'b1, 4'd9, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0));
    vecs.push_back(mk(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0));
    vecs.push_back(mk(1'b1, 4'd9, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2'd0));
    vecs.push_back(mk(1'b0, 4'd0, 1'b1, 4'd9, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0));
    vecs.push_back(mk(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0));
    vecs.push_back(mk(1'b1, 4'd9, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2'd1));
    // D: index 7 bypass. Same-cycle lookup sees old value, next cycle sees new.
    vecs.push_back(mk(1'b1, 4'd7, 1'b1, 4'd7, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 2'd1));
    vecs.push_back(mk(1'b1, 4'd7, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2'd2));
    vecs.push_back(mk(1'b1, 4'd7, 1'b1, 4'd7, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2'd2));
    vecs.push_back(mk(1'b1, 4'd7, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2'd1));
    // D': in-flight write to 7 must not leak into a lookup of 6.
    vecs.push_back(mk(1'b0, 4'd0, 1'b1, 4'd7, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0));
    vecs.push_back(mk(1'b1, 4'd6, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2'd1));
    vecs.push_back(mk(1'b1, 4'd7, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2'd2));
    // E: clear with an update to 5 (5 holds 3). Lookups in clear/INIT give 1.
    vecs.push_back(mk(1'b1, 4'd5, 1'b1, 4'd5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 2'd1));
    vecs.push_back(mk(1'b1, 4'd5, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd1));
    vecs.push_back(mk(1'b0, 4'd0, 1'b1, 4'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0));
    for (int i = 0; i < 13; i++)
      vecs.push_back(mk(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0));
    // Last INIT cycle: the commit is dropped; ready rises after this edge.
    vecs.push_back(mk(1'b0, 4'd0, 1'b1, 4'd9, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0));
    vecs.push_back(mk(1'b1, 4'd5, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2'd1));
    // First RUN-cycle commit to 9 is accepted; lookup after shows bypass value.
    vecs.push_back(mk(1'b1, 4'd9, 1'b1, 4'd9, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 2'd1));
    vecs.push_back(mk(1'b1, 4'd9, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2'd2));

    foreach (vecs[i]) begin
      v = vecs[i];
      bim_if.i_bim_clr   = v.clr;
      bim_if.i_bpu_vld   = v.bpu_vld;
      bim_if.i_bpu_addr  = v.bpu_addr;
      bim_if.i_cmt_req   = v.cmt_req;
      bim_if.i_cmt_addr  = v.cmt_addr;
      bim_if.i_cmt_taken = v.cmt_taken;
      tick();
      check($sformatf("v%0d_vld", i),   32'(bim_if.o_bim_vld),   32'(v.exp_vld));
      check($sformatf("v%0d_ready", i), 32'(bim_if.o_bim_ready), 32'(v.exp_ready));
      if (v.chk_cnt) begin
        check($sformatf("v%0d_cnt", i), 32'(bim_if.o_bim_cnt),   32'(v.exp_cnt));
        check($sformatf("v%0d_tkn", i), 32'(bim_if.o_bim_taken), 32'(v.exp_cnt[CNT_W-1]));
      end
    end
    drive_idle();

    // ---------------- async reset mid-sweep ----------------
    bim_if.i_bim_clr  = 1'b1;
    bim_if.i_bpu_vld  = 1'b1;
    bim_if.i_bpu_addr = 4'd0;
    tick();
    bim_if.i_bim_clr  = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    check("mid_ready", 32'(bim_if.o_bim_ready), 32'd0);
    check("mid_vld",   32'(bim_if.o_bim_vld),   32'd1);
    check("mid_cnt",   32'(bim_if.o_bim_cnt),   32'd1);
    rst_n = 1'b0;
    #1;
    check("arst_vld",   32'(bim_if.o_bim_vld),   32'd0);
    check("arst_cnt",   32'(bim_if.o_bim_cnt),   32'd0);
    check("arst_taken", 32'(bim_if.o_bim_taken), 32'd0);
    check("arst_ready", 32'(bim_if.o_bim_ready), 32'd0);
    tick();
    check("arst_hold_vld", 32'(bim_if.o_bim_vld), 32'd0);
    bim_if.i_bpu_vld = 1'b0;
    tick();
    rst_n = 1'b1;
    sweep_check("resweep");
    lookup_check("post_rst_idx0", 4'd0, 2'd1);
    lookup_check("post_rst_idx15", 4'd15, 2'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/xcore_if_bim_sat.md
# xcore_if_bim_sat

Parametrised bimodal branch-prediction table for the Xcore fetch-stage BPU. It holds ENTRIES saturating counters of CNT_W bits each and answers one fetch lookup per cycle with one-cycle latency. It applies commit-time outcome updates internally as a read-modify-write, rather than accepting precomputed counter bits. A hardware init sweep clears the table after reset or on request, so the array itself needs no reset.

## Interface
- ENTRIES, 1024, number of counters; power of two, at least 16
- IDX_W, $clog2(ENTRIES), index width
- CNT_W, 2, counter width; 2 to 4
- INIT_VAL, 2^(CNT_W-1)-1, counter value written by the init sweep (weakly not-taken)
- i_sys_clk  in  1  sole clock; all state changes on the rising edge
- i_sys_rst  in  1  reset, asynchronous, active-low
- i_bim_clr  in  1  synchronous request to restart the init sweep
- i_bpu_vld  in  1  lookup request
- i_bpu_addr  in  IDX_W  lookup index
- i_cmt_req  in  1  resolved-branch update request
- i_cmt_addr  in  IDX_W  update index
- i_cmt_taken  in  1  resolved direction (1 = taken)
- o_bim_ready  out  1  init sweep complete; updates are accepted
- o_bim_vld  out  1  lookup result valid
- o_bim_cnt  out  CNT_W  counter value for the lookup
- o_bim_taken  out  1  prediction, equal to the MSB of o_bim_cnt

## Operation
- The FSM has two states, INIT and RUN.
  - Reset enters INIT with the sweep index at 0.
  - INIT writes INIT_VAL to one entry per cycle, index 0 to ENTRIES-1, then moves to RUN.
  - i_bim_clr in either state forces INIT with the index at 0.
- Updates use a 2-stage pipeline.
  - U1 registers i_cmt_req, i_cmt_addr and i_cmt_taken.
  - U2 reads mem[U1 addr] and computes the next counter value, then writes it.
  - Taken: cnt+1, saturating at 2^CNT_W-1. Not taken: cnt-1, saturating at 0.
- Updates presented while the FSM is in INIT, or in the cycle i_bim_clr is high, are dropped. The U1 valid bit is cleared on entering INIT.
- Lookup: o_bim_cnt is registered from mem[i_bpu_addr].
  - Bypass: if the U2 write index equals the lookup index in the same cycle, the new value is returned instead of the stale entry.
  - In INIT, or in the clear cycle, the lookup returns INIT_VAL regardless of the index; fetch is never stalled.
- o_bim_vld is i_bpu_vld delayed by 1 cycle, in every state.
- Back-to-back updates to the same index accumulate with no loss: the write completes before the next U2 read.

## Timing
- Reset values:
  - o_bim_ready=0, o_bim_vld=0, o_bim_cnt=0, o_bim_taken=0
  - FSM=INIT, sweep index=0, U1 valid=0
- Init duration: exactly ENTRIES cycles after reset deassertion, or after the i_bim_clr cycle. o_bim_ready rises in the cycle after the last sweep write.
- Lookup latency: request in cycle t, result valid in cycle t+1.
- Update latency:
  - cmt in cycle t is registered at the end of t.
  - The memory is written at the end of t+1.
  - A lookup of that index issued in cycle t+1 or later reflects the update.
- One update and one lookup are accepted per cycle with no backpressure. The updater must not present a cmt while o_bim_ready=0; if it does, the cmt is silently discarded.
- Async reset mid-sweep or mid-update:
  - Reset aborts immediately; the pending U2 write is lost.
  - Table contents are undefined until the new sweep finishes.
- Sweep index wrap: the index compares against ENTRIES-1; no modulo overflow occurs for any power-of-two ENTRIES.

## Structure
- Shared package xcore_bpu_pkg holds:
  - the FSM state enum (INIT, RUN)
  - the default CNT_W
  - the INIT_VAL encoding
  - a saturating-update function, sat_next(cnt, taken), reused by future BHT/tournament tables
- One sub-module, xcore_bim_ram:
  - ENTRIES x CNT_W array
  - one synchronous write port (shared by the sweep and U2)
  - two combinational read ports (lookup, U2)
  - no reset on the array
- The top holds the FSM, the sweep counter, the U1/U2 registers, the bypass mux and the output registers.

## Test plan
- Reset, release, idle, ENTRIES=16: o_bim_ready=0 for 16 cycles, 1 on cycle 17. Lookups of indices 0..15 afterwards return cnt=1, taken=0.
- Three taken updates to index 5 on consecutive cycles, then a lookup of 5 at cycle +2: cnt=3, taken=1. A fourth taken update leaves cnt=3 (saturation).
- Index 9 driven to 0 via not-taken updates, then one more not-taken: cnt stays 0. One taken update then gives cnt=1.
- Update to index 7 in cycle t and lookup of 7 in cycle t+1: o_bim_cnt at t+2 shows the updated value (bypass path).
- From RUN with index 5 at 3, assert i_bim_clr together with an update: the update is dropped, o_bim_ready=0 for 16 cycles, and index 5 then reads 1.
- Async reset pulse mid-sweep at index 8: outputs reset immediately; after release the full 16-cycle sweep runs from index 0.
